// File: rtl/cpc_mem_mapper.sv
// CPC memory/ROM mapper: RAM configuration and upper-ROM select registers,
// the 16K page map for RAM_BANKS 64K expansion blocks, and the ROM read enables.
module cpc_mem_mapper #(
    parameter int unsigned RAM_BANKS   = 1,
    parameter logic [15:0] ROM_PRESENT = 16'h00C1,
    localparam int unsigned PA_W       = 16 + $clog2(RAM_BANKS + 1)
) (
    input  logic            clk_i,
    input  logic            nreset_i,
    input  logic [15:0]     a_i,
    input  logic [7:0]      d_i,
    input  logic            nIORQ_i,
    input  logic            nMREQ_i,
    input  logic            nRD_i,
    input  logic            nWR_i,
    input  logic            lrom_en_i,
    input  logic            urom_en_i,
    output logic [PA_W-1:0] ram_addr_o,
    output logic            ram_we_o,
    output logic            lrom_e_o,
    output logic            urom_e_o,
    output logic            urom_absent_o,
    output logic [3:0]      romsel_o,
    output logic [2:0]      cfg_o,
    output logic [2:0]      bank_o
);

    // Width of the 64K-block part of the physical address.
    localparam int unsigned HI_W = PA_W - 16;
    localparam logic [2:0] BANK_MASK = 3'(RAM_BANKS - 1);

    logic [1:0] wr_hist_q, wr_hist_d;
    logic [2:0] cfg_q, cfg_d;
    logic [2:0] bank_q, bank_d;
    logic [3:0] romsel_q, romsel_d;

    logic       iowr_act;
    logic       wr_pulse;
    logic       cfg_hit;
    logic       rom_hit;
    logic [1:0] page;
    logic [2:0] blk;
    logic       mrd;
    logic       upper_rd;

    assign iowr_act = !nIORQ_i && !nWR_i;
    // One pulse at the first sampled-active cycle after an inactive one.
    assign wr_pulse = (wr_hist_q == 2'b01);
    assign cfg_hit  = !a_i[15] && (d_i[7:6] == 2'b11);
    assign rom_hit  = !a_i[13];

    // Next-state for the write-edge history and the two mapper registers.
    always_comb begin
        wr_hist_d = {wr_hist_q[0], iowr_act};
        cfg_d     = cfg_q;
        bank_d    = bank_q;
        romsel_d  = romsel_q;
        if (wr_pulse) begin
            if (cfg_hit) begin
                cfg_d  = d_i[2:0];
                bank_d = d_i[5:3] & BANK_MASK;
            end
            if (rom_hit) begin
                romsel_d = d_i[3:0];
            end
        end
    end

    // State registers; history resets to 11 so a write in flight at release is ignored.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            wr_hist_q <= 2'b11;
            cfg_q     <= 3'd0;
            bank_q    <= 3'd0;
            romsel_q  <= 4'd0;
        end else begin
            wr_hist_q <= wr_hist_d;
            cfg_q     <= cfg_d;
            bank_q    <= bank_d;
            romsel_q  <= romsel_d;
        end
    end

    assign page = a_i[15:14];

    // 16K block index for the current page under the current RAM configuration.
    always_comb begin
        blk = {1'b0, page};
        unique case (cfg_q)
            3'd0: blk = {1'b0, page};
            3'd1: blk = (page == 2'd3) ? 3'd7 : {1'b0, page};
            3'd2: blk = {1'b1, page};
            3'd3: begin
                unique case (page)
                    2'd0: blk = 3'd0;
                    2'd1: blk = 3'd3;
                    2'd2: blk = 3'd2;
                    2'd3: blk = 3'd7;
                    default: blk = 3'd0;
                endcase
            end
            // c4..c7 swap page 1 for block 4..7, which equals the cfg value.
            default: blk = (page == 2'd1) ? cfg_q : {1'b0, page};
        endcase
    end

    // Blocks 4..7 live in expansion 64K block (1 + bank); blocks 0..3 in the base 64K.
    always_comb begin
        if (blk[2]) begin
            ram_addr_o = {HI_W'(bank_q) + HI_W'(1), blk[1:0], a_i[13:0]};
        end else begin
            ram_addr_o = {HI_W'(0), blk[1:0], a_i[13:0]};
        end
    end

    assign mrd      = !nMREQ_i && !nRD_i;
    assign upper_rd = mrd && (page == 2'd3) && urom_en_i;

    // Read enables toward the data-bus arbiter; page 0 and page 3 are exclusive.
    always_comb begin
        ram_we_o      = !nMREQ_i && !nWR_i;
        lrom_e_o      = mrd && (page == 2'd0) && lrom_en_i;
        urom_e_o      = upper_rd && ROM_PRESENT[romsel_q];
        urom_absent_o = upper_rd && !ROM_PRESENT[romsel_q];
    end

    assign cfg_o    = cfg_q;
    assign bank_o   = bank_q;
    assign romsel_o = romsel_q;

endmodule

// File: tb/tb_cpc_mem_mapper.sv
// Directed bench for cpc_mem_mapper: one instance with RAM_BANKS=1, one with RAM_BANKS=4,
// both driven from the same CPU bus.
module tb_cpc_mem_mapper;

    logic        clk_i = 1'b0;
    logic        nreset_i = 1'b0;
    logic [15:0] a_i = 16'h0000;
    logic [7:0]  d_i = 8'h00;
    logic        nIORQ_i = 1'b1;
    logic        nMREQ_i = 1'b1;
    logic        nRD_i = 1'b1;
    logic        nWR_i = 1'b1;
    logic        lrom_en_i = 1'b1;
    logic        urom_en_i = 1'b0;

    logic [16:0] addr1;
    logic        we1, lrom1, urom1, absent1;
    logic [3:0]  romsel1;
    logic [2:0]  cfg1, bank1;

    logic [18:0] addr4;
    logic        we4, lrom4, urom4, absent4;
    logic [3:0]  romsel4;
    logic [2:0]  cfg4, bank4;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk_i = ~clk_i;

    cpc_mem_mapper #(.RAM_BANKS(1), .ROM_PRESENT(16'h00C1)) u_dut1 (
        .clk_i(clk_i), .nreset_i(nreset_i), .a_i(a_i), .d_i(d_i),
        .nIORQ_i(nIORQ_i), .nMREQ_i(nMREQ_i), .nRD_i(nRD_i), .nWR_i(nWR_i),
        .lrom_en_i(lrom_en_i), .urom_en_i(urom_en_i),
        .ram_addr_o(addr1), .ram_we_o(we1), .lrom_e_o(lrom1), .urom_e_o(urom1),
        .urom_absent_o(absent1), .romsel_o(romsel1), .cfg_o(cfg1), .bank_o(bank1)
    );

    cpc_mem_mapper #(.RAM_BANKS(4), .ROM_PRESENT(16'h00C1)) u_dut4 (
        .clk_i(clk_i), .nreset_i(nreset_i), .a_i(a_i), .d_i(d_i),
        .nIORQ_i(nIORQ_i), .nMREQ_i(nMREQ_i), .nRD_i(nRD_i), .nWR_i(nWR_i),
        .lrom_en_i(lrom_en_i), .urom_en_i(urom_en_i),
        .ram_addr_o(addr4), .ram_we_o(we4), .lrom_e_o(lrom4), .urom_e_o(urom4),
        .urom_absent_o(absent4), .romsel_o(romsel4), .cfg_o(cfg4), .bank_o(bank4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // IO write held for two sampling edges; the load happens on the second.
    task automatic io_write(input logic [15:0] addr, input logic [7:0] data);
        @(negedge clk_i);
        a_i = addr; d_i = data; nIORQ_i = 1'b0; nWR_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        nIORQ_i = 1'b1; nWR_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic mem_read(input logic [15:0] addr);
        @(negedge clk_i);
        a_i = addr; nMREQ_i = 1'b0; nRD_i = 1'b0; nWR_i = 1'b1;
        #1;
    endtask

    task automatic mem_idle();
        nMREQ_i = 1'b1; nRD_i = 1'b1; nWR_i = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        nreset_i = 1'b1;
        @(negedge clk_i);

        // Reset state and lower ROM
        mem_read(16'h0000);
        check("rst_lrom", lrom1, 1);
        check("rst_addr", addr1, 0);
        check("rst_cfg", cfg1, 0);
        check("rst_romsel", romsel1, 0);
        check("rst_urom", urom1, 0);
        mem_idle();

        // c1 on single-bank build
        io_write(16'h7FFF, 8'hC1);
        check("c1_cfg", cfg1, 1);
        check("c1_romsel_untouched", romsel1, 0);
        mem_read(16'hC123);
        check("c1_addr_p3", addr1, 32'h1C123);
        check("c1_lrom_p3", lrom1, 0);
        mem_read(16'h4123);
        check("c1_addr_p1", addr1, 32'h04123);
        mem_idle();

        // Expansion bank and wrap
        io_write(16'h7FFF, 8'hD4);
        mem_read(16'h4010);
        check("b2c4_addr4", addr4, 32'h30010);
        check("b2c4_bank4", bank4, 2);
        check("b2c4_addr1", addr1, 32'h10010);
        check("b2c4_bank1", bank1, 0);
        mem_idle();
        io_write(16'h7FFF, 8'hFC);
        mem_read(16'h4010);
        check("b7wrap_addr4", addr4, 32'h40010);
        check("b7wrap_bank4", bank4, 3);
        check("b7wrap_cfg4", cfg4, 4);
        mem_idle();

        // RAM write enable
        @(negedge clk_i);
        a_i = 16'h4010; nMREQ_i = 1'b0; nWR_i = 1'b0; #1;
        check("ram_we", we4, 1);
        mem_idle(); #1;
        check("ram_we_idle", we4, 0);

        // Upper ROM presence
        urom_en_i = 1'b1;
        io_write(16'hDFFF, 8'h05);
        check("rs5_romsel", romsel4, 5);
        check("rs5_cfg_kept", cfg4, 4);
        mem_read(16'hC000);
        check("rs5_absent", absent4, 1);
        check("rs5_urom", urom4, 0);
        check("rs5_lrom", lrom4, 0);
        mem_idle();
        io_write(16'hDFFF, 8'h07);
        mem_read(16'hC000);
        check("rs7_urom", urom1, 1);
        check("rs7_absent", absent1, 0);
        mem_idle();
        urom_en_i = 1'b0;
        mem_read(16'hC000);
        check("urom_dis", urom1, 0);
        mem_idle();

        // Long write: single load, later data change ignored
        @(negedge clk_i);
        a_i = 16'h7FFF; d_i = 8'hC2; nIORQ_i = 1'b0; nWR_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("hold_loaded", cfg4, 2);
        repeat (3) @(negedge clk_i);
        d_i = 8'hC3;
        repeat (5) @(negedge clk_i);
        nIORQ_i = 1'b1; nWR_i = 1'b1;
        @(negedge clk_i);
        check("hold_cfg", cfg4, 2);
        check("hold_bank", bank4, 0);

        // Both decodes in one write
        io_write(16'h5FFF, 8'hC6);
        check("dual_cfg", cfg1, 6);
        check("dual_romsel", romsel1, 6);

        // Reset during an active write
        @(negedge clk_i);
        nreset_i = 1'b0;
        a_i = 16'h7FFF; d_i = 8'hC5; nIORQ_i = 1'b0; nWR_i = 1'b0;
        repeat (3) @(negedge clk_i);
        nreset_i = 1'b1;
        repeat (4) @(negedge clk_i);
        check("rstwr_cfg", cfg4, 0);
        check("rstwr_romsel", romsel4, 0);
        nIORQ_i = 1'b1; nWR_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check("rstwr_cfg_after", cfg4, 0);
        io_write(16'h7FFF, 8'hC3);
        check("rstwr_next", cfg4, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
